// File: rtl/branch_pred_ctrl.sv
`timescale 1ns/1ps
// branch_pred_ctrl
//   Branch prediction controller for a 5-stage RISC-V pipeline. Holds a
//   direct-mapped table of 2-bit saturating counters with a BTB (tag + target),
//   gives IF a same-cycle prediction, trains from resolved EX branches, flags
//   mispredicts with the redirect PC, and keeps branch / mispredict statistics.
//   After reset the table is cleared by a one-entry-per-cycle sweep.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   if_pc_i               IF fetch PC
//   pred_hit_o            BTB hit for if_pc_i
//   pred_taken_o          predicted taken
//   pred_target_o         predicted next PC (stored target or if_pc_i + 4)
//   ex_valid_i            EX instruction valid (not a bubble / flushed)
//   ex_opcode_i           EX opcode; only conditional branches train the table
//   ex_pc_i               PC of the EX instruction
//   ex_taken_i            resolved outcome
//   ex_target_i           resolved target
//   ex_pred_taken_i       prediction carried down the pipe
//   ex_pred_target_i      predicted target carried down the pipe
//   mispredict_o          flush request
//   redirect_pc_o         correct next PC, meaningful when mispredict_o = 1
//   init_busy_o           table sweep in progress, IF must stall
//   branch_cnt_o          resolved branches since reset (saturating)
//   mispred_cnt_o         mispredicts since reset (saturating)
//   dbg_state             FSM state for checkers: 0 = INIT, 1 = RUN
//
// Handshake: the EX interface has no ready. A resolved branch is accepted in
//   the cycle where ex_valid_i = 1 and the FSM is in RUN; during INIT it is
//   silently dropped (IF is stalled then, so no real branch can be in flight).
module branch_pred_ctrl #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [PC_W-1:0]  if_pc_i,
  output logic             pred_hit_o,
  output logic             pred_taken_o,
  output logic [PC_W-1:0]  pred_target_o,
  input  logic             ex_valid_i,
  input  logic [6:0]       ex_opcode_i,
  input  logic [PC_W-1:0]  ex_pc_i,
  input  logic             ex_taken_i,
  input  logic [PC_W-1:0]  ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic [PC_W-1:0]  ex_pred_target_i,
  output logic             mispredict_o,
  output logic [PC_W-1:0]  redirect_pc_o,
  output logic             init_busy_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic             dbg_state
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = PC_W - IDX_W - 2;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] sweep;

  // Table storage; contents are cleared by the sweep rather than by reset.
  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [PC_W-1:0]  tbl_target [ENTRIES];
  logic [1:0]       tbl_ctr    [ENTRIES];

  logic             run;
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             update_en;
  logic [1:0]       ex_ctr_next;

  assign run    = (state == ST_RUN);
  assign if_idx = if_pc_i[IDX_W+1:2];
  assign if_tag = if_pc_i[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc_i[IDX_W+1:2];
  assign ex_tag = ex_pc_i[PC_W-1:IDX_W+2];

  // Lookup reads the pre-edge table, so a same-cycle update to the same index
  // is only visible from the next cycle on.
  assign pred_hit_o    = run & tbl_valid[if_idx] & (tbl_tag[if_idx] == if_tag);
  assign pred_taken_o  = pred_hit_o & tbl_ctr[if_idx][1];
  assign pred_target_o = pred_taken_o ? tbl_target[if_idx] : (if_pc_i + PC_W'(4));

  assign update_en = run & ex_valid_i & (ex_opcode_i == OP_BRANCH);
  assign ex_hit    = tbl_valid[ex_idx] & (tbl_tag[ex_idx] == ex_tag);

  // A correctly predicted not-taken branch never mispredicts on target.
  assign mispredict_o  = update_en &
                         ((ex_taken_i != ex_pred_taken_i) |
                          (ex_taken_i & (ex_target_i != ex_pred_target_i)));
  assign redirect_pc_o = ex_taken_i ? ex_target_i : (ex_pc_i + PC_W'(4));

  assign init_busy_o = (state == ST_INIT);
  assign dbg_state   = run;

  // Saturating 2-bit counter step for a hit.
  always_comb begin
    ex_ctr_next = tbl_ctr[ex_idx];
    if (ex_taken_i) begin
      if (tbl_ctr[ex_idx] != 2'b11) ex_ctr_next = tbl_ctr[ex_idx] + 2'b01;
    end else begin
      if (tbl_ctr[ex_idx] != 2'b00) ex_ctr_next = tbl_ctr[ex_idx] - 2'b01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_INIT;
      sweep         <= '0;
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (state == ST_INIT) begin
      tbl_valid[sweep] <= 1'b0;
      tbl_ctr[sweep]   <= 2'b01;
      sweep            <= sweep + 1'b1;
      if (&sweep) state <= ST_RUN;
    end else if (update_en) begin
      if (ex_hit) begin
        tbl_ctr[ex_idx] <= ex_ctr_next;
        if (ex_taken_i) tbl_target[ex_idx] <= ex_target_i;
      end else begin
        tbl_valid[ex_idx]  <= 1'b1;
        tbl_tag[ex_idx]    <= ex_tag;
        tbl_target[ex_idx] <= ex_target_i;
        tbl_ctr[ex_idx]    <= ex_taken_i ? 2'b10 : 2'b01;
      end
      if (branch_cnt_o != '1) branch_cnt_o <= branch_cnt_o + 1'b1;
      if (mispredict_o && (mispred_cnt_o != '1)) mispred_cnt_o <= mispred_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
`timescale 1ns/1ps
module tb_branch_pred_ctrl;

  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_ALU = 7'b0110011;
  localparam int EXP_W = 101;

  // Expected view of every observable output for one cycle.
  typedef struct packed {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic [31:0] redirect;
    logic        busy;
    logic        st;
    logic [15:0] bcnt;
    logic [15:0] mcnt;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] if_pc_i = '0;
  logic        pred_hit_o, pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i = 1'b0;
  logic [6:0]  ex_opcode_i = OP_ALU;
  logic [31:0] ex_pc_i = '0;
  logic        ex_taken_i = 1'b0;
  logic [31:0] ex_target_i = '0;
  logic        ex_pred_taken_i = 1'b0;
  logic [31:0] ex_pred_target_i = '0;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        init_busy_o;
  logic [15:0] branch_cnt_o, mispred_cnt_o;
  logic        dbg_state;

  branch_pred_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .if_pc_i(if_pc_i),
    .pred_hit_o(pred_hit_o), .pred_taken_o(pred_taken_o), .pred_target_o(pred_target_o),
    .ex_valid_i(ex_valid_i), .ex_opcode_i(ex_opcode_i), .ex_pc_i(ex_pc_i),
    .ex_taken_i(ex_taken_i), .ex_target_i(ex_target_i),
    .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_target_i(ex_pred_target_i),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .init_busy_o(init_busy_o), .branch_cnt_o(branch_cnt_o),
    .mispred_cnt_o(mispred_cnt_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_known = 0;
  bit          m_busy;
  int          m_sweep;
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [1:0]  m_ctr   [64];
  logic [15:0] m_bcnt, m_mcnt;

  logic [EXP_W-1:0] exp_q[$];

  function automatic exp_t model_out();
    exp_t e;
    int   i;
    i = int'(if_pc_i[7:2]);
    e.hit      = !m_busy && m_valid[i] && (m_tag[i] == if_pc_i[31:8]);
    e.taken    = e.hit && m_ctr[i][1];
    e.target   = e.taken ? m_tgt[i] : if_pc_i + 32'd4;
    e.misp     = !m_busy && ex_valid_i && (ex_opcode_i == OP_BR) &&
                 ((ex_taken_i != ex_pred_taken_i) ||
                  (ex_taken_i && (ex_target_i != ex_pred_target_i)));
    e.redirect = ex_taken_i ? ex_target_i : ex_pc_i + 32'd4;
    e.busy     = m_busy;
    e.st       = !m_busy;
    e.bcnt     = m_bcnt;
    e.mcnt     = m_mcnt;
    return e;
  endfunction

  // Advance the model across one rising edge, using the inputs held at that edge.
  task automatic model_step();
    exp_t e;
    bit   upd;
    int   i;
    e   = model_out();
    upd = !m_busy && ex_valid_i && (ex_opcode_i == OP_BR);
    i   = int'(ex_pc_i[7:2]);
    if (rst_i) begin
      m_known = 1; m_busy = 1; m_sweep = 0; m_bcnt = '0; m_mcnt = '0;
    end else if (!m_known) begin
      // state before the first reset is undefined; nothing to model
    end else if (m_busy) begin
      m_valid[m_sweep] = 0;
      m_ctr[m_sweep]   = 2'b01;
      if (m_sweep == 63) m_busy = 0;
      m_sweep = (m_sweep + 1) % 64;
    end else if (upd) begin
      if (m_valid[i] && m_tag[i] == ex_pc_i[31:8]) begin
        if (ex_taken_i) begin
          if (m_ctr[i] < 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
          m_tgt[i] = ex_target_i;
        end else if (m_ctr[i] > 2'd0) begin
          m_ctr[i] = m_ctr[i] - 2'd1;
        end
      end else begin
        m_valid[i] = 1;
        m_tag[i]   = ex_pc_i[31:8];
        m_tgt[i]   = ex_target_i;
        m_ctr[i]   = ex_taken_i ? 2'b10 : 2'b01;
      end
      if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
      if (e.misp && m_mcnt != 16'hFFFF) m_mcnt = m_mcnt + 16'd1;
    end
  endtask

  // ---------------- driver ----------------
  // Entered 1 ns after a rising edge; returns 1 ns after the next one.
  task automatic cycle(input logic rst, input logic [31:0] pc, input logic ev,
                       input logic [6:0] op, input logic [31:0] epc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    exp_t e;
    rst_i = rst; if_pc_i = pc; ex_valid_i = ev; ex_opcode_i = op; ex_pc_i = epc;
    ex_taken_i = tk; ex_target_i = tgt; ex_pred_taken_i = ptk; ex_pred_target_i = ptgt;
    #1;
    if (m_known) exp_q.push_back(model_out());
    @(negedge clk_i);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pred_hit",      32'(pred_hit_o),    32'(e.hit));
      check("pred_taken",    32'(pred_taken_o),  32'(e.taken));
      check("pred_target",   pred_target_o,      e.target);
      check("mispredict",    32'(mispredict_o),  32'(e.misp));
      check("redirect_pc",   redirect_pc_o,      e.redirect);
      check("init_busy",     32'(init_busy_o),   32'(e.busy));
      check("dbg_state",     32'(dbg_state),     32'(e.st));
      check("branch_cnt",    32'(branch_cnt_o),  32'(e.bcnt));
      check("mispred_cnt",   32'(mispred_cnt_o), 32'(e.mcnt));
      if (init_busy_o === 1'b1) busy_seen++;
    end
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic idle(input logic [31:0] pc);
    cycle(1'b0, pc, 1'b0, OP_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic br(input logic [31:0] pc, input logic [31:0] epc, input logic tk,
                    input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    cycle(1'b0, pc, 1'b1, OP_BR, epc, tk, tgt, ptk, ptgt);
  endtask

  // Reset pulse followed by the sweep; also drives ignored EX branches.
  task automatic reset_and_sweep();
    cycle(1'b1, 32'h40, 1'b1, OP_BR, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    busy_seen = 0;
    for (int i = 0; i < 70; i++)
      cycle(1'b0, 32'($urandom_range(0, 255)) << 2, 1'b1, OP_BR,
            32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)),
            32'h300, 1'b0, 32'h0);
    check("sweep_cycles", 32'(busy_seen), 32'd64);
  endtask

  function automatic logic [31:0] pick_tgt();
    case ($urandom_range(0, 2))
      0:       return 32'h200;
      1:       return 32'h300;
      default: return 32'h400;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk_i);
    #1;
    reset_and_sweep();

    // Cold branch: miss, taken -> mispredict, then allocated as taken.
    br(32'h0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    idle(32'h100);
    check("cold_redirect", 32'h200, m_tgt[0]);

    // Saturation: up to 3, down to 0.
    for (int i = 0; i < 4; i++) br(32'h100, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    br(32'h100, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    idle(32'h100);
    br(32'h100, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
    br(32'h100, 32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
    idle(32'h100);
    check("sat_ctr_zero", 32'(m_ctr[0]), 32'd0);

    // Aliasing: 0x200 shares index 0 with 0x100 and evicts it.
    br(32'h100, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    br(32'h100, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
    idle(32'h100);
    idle(32'h200);

    // Wrong target on a predicted-taken branch.
    br(32'h0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    br(32'h100, 32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    idle(32'h100);

    // Same-cycle lookup and update: old prediction, new value next cycle.
    br(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    br(32'h100, 32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
    idle(32'h100);

    // Non-branch opcode: no count, no mispredict.
    cycle(1'b0, 32'h100, 1'b1, OP_ALU, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0);
    // Wrapping fall-through address.
    idle(32'hFFFF_FFFC);

    // Random traffic over a few indices and tags.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] epc;
      epc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      cycle(1'b0, (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2),
            1'($urandom_range(0, 7) != 0),
            ($urandom_range(0, 3) == 0) ? OP_ALU : OP_BR,
            epc, 1'($urandom_range(0, 1)), pick_tgt(),
            1'($urandom_range(0, 1)), pick_tgt());
    end

    // Mid-run reset: counters clear, sweep restarts, table reads empty after.
    reset_and_sweep();
    idle(32'h100);
    br(32'h104, 32'h104, 1'b0, 32'h0, 1'b1, 32'h200);
    idle(32'h104);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
